// File: rtl/chi_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chi_stream_pkg
// Purpose  : Shared types and constants for the Keccak slice pipeline
//            (pi, chi and iota stages).
// Revision : 1.0
// ============================================================================
package chi_stream_pkg;

    localparam int SLICE_W  = 25;
    localparam int ROW_W    = 5;
    localparam int NUM_ROWS = 5;

    // Within a slice, lane A[x][y] is stored at bit LANE_Y_STRIDE*y + x.
    localparam int LANE_Y_STRIDE = ROW_W;
    localparam int LANE_X_STRIDE = 1;

    typedef logic [SLICE_W-1:0] slice_t;

    typedef logic [1:0] chi_state_t;
    localparam chi_state_t ST_IDLE  = 2'd0;
    localparam chi_state_t ST_RUN   = 2'd1;
    localparam chi_state_t ST_DRAIN = 2'd2;
    localparam chi_state_t ST_DONE  = 2'd3;

    function automatic int lane_idx(input int x, input int y);
        return LANE_Y_STRIDE * y + LANE_X_STRIDE * x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chi_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : chi_stream_if
// Purpose  : Slice-stream handshake bundle between the upstream permute stage,
//            the chi stage and the downstream iota stage / writer.
// Revision : 1.0
// ============================================================================
interface chi_stream_if #(
    parameter int IDX_W = 6
);
    import chi_stream_pkg::*;

    logic             start;
    logic             in_valid;
    slice_t           in_slice;
    logic             in_ready;
    logic             out_valid;
    slice_t           out_slice;
    logic [IDX_W-1:0] out_index;
    logic             out_ready;
    logic             busy;
    logic             done;

    // Controller / environment side.
    modport master (
        output start, in_valid, in_slice, out_ready,
        input  in_ready, out_valid, out_slice, out_index, busy, done
    );

    // Chi stage side.
    modport slave (
        input  start, in_valid, in_slice, out_ready,
        output in_ready, out_valid, out_slice, out_index, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/chi_slice.sv
`default_nettype none
// ============================================================================
// Module   : chi_slice
// Purpose  : Combinational chi over one 25-bit slice: five independent rows,
//            B[x] = A[x] ^ (~A[x+1] & A[x+2]) with x taken mod 5.
// Revision : 1.0
// ============================================================================
module chi_slice
    import chi_stream_pkg::*;
(
    input  slice_t i_slice,
    output slice_t o_slice
);

    for (genvar y = 0; y < NUM_ROWS; y++) begin : g_row
        for (genvar x = 0; x < ROW_W; x++) begin : g_lane
            assign o_slice[lane_idx(x, y)] =
                i_slice[lane_idx(x, y)] ^
                (~i_slice[lane_idx((x + 1) % ROW_W, y)] &
                  i_slice[lane_idx((x + 2) % ROW_W, y)]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/chi_stream.sv
`default_nettype none
// ============================================================================
// Module   : chi_stream
// Purpose  : Streaming Keccak chi stage; one 25-bit slice per cycle through a
//            single output register, framed by a start/done controller.
// Revision : 1.0
// ============================================================================
module chi_stream
    import chi_stream_pkg::*;
#(
    parameter int SLICES = 64,
    parameter int IDX_W  = 6
) (
    input  wire logic    clk,
    input  wire logic    rst,
    chi_stream_if.slave  bus
);

    localparam logic [IDX_W:0] c_last = (IDX_W + 1)'(SLICES - 1);
    localparam logic [IDX_W:0] c_one  = (IDX_W + 1)'(1);

    chi_state_t        r_state;
    chi_state_t        w_state_nxt;
    logic [IDX_W:0]    r_in_cnt;
    logic [IDX_W:0]    r_out_cnt;
    logic              r_out_valid;
    slice_t            r_out_slice;
    logic [IDX_W-1:0]  r_out_index;

    logic              w_in_ready;
    logic              w_busy;
    logic              w_done;
    logic              w_in_xfer;
    logic              w_out_xfer;
    slice_t            w_chi;

    assign w_in_xfer  = bus.in_valid && w_in_ready;
    assign w_out_xfer = r_out_valid && bus.out_ready;

    chi_slice u_chi (
        .i_slice (bus.in_slice),
        .o_slice (w_chi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start)                          w_state_nxt = ST_RUN;
            ST_RUN:   if (w_in_xfer && (r_in_cnt == c_last))  w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_out_xfer && (r_out_cnt == c_last)) w_state_nxt = ST_DONE;
            ST_DONE:                                          w_state_nxt = ST_IDLE;
            default:                                          w_state_nxt = ST_IDLE;
        endcase
    end

    // A new slice may enter whenever the output register is free or draining
    // this cycle; in_valid deliberately does not feed back into in_ready.
    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_in_ready = !r_out_valid || bus.out_ready;
                w_busy     = 1'b1;
            end
            ST_DRAIN: w_busy = 1'b1;
            ST_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_slice <= '0;
            r_out_index <= '0;
        end else begin
            if ((r_state == ST_IDLE) && bus.start) begin
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
            end else begin
                if (w_in_xfer)  r_in_cnt  <= r_in_cnt + c_one;
                if (w_out_xfer) r_out_cnt <= r_out_cnt + c_one;
            end

            if (w_in_xfer) begin
                r_out_slice <= w_chi;
                r_out_index <= r_in_cnt[IDX_W-1:0];
                r_out_valid <= 1'b1;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_slice = r_out_slice;
    assign bus.out_index = r_out_index;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_chi_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_chi_stream
// Purpose  : Directed and randomized-handshake bench for chi_stream.
// Revision : 1.0
// ============================================================================
module tb_chi_stream;

    localparam int SLICES = 64;
    localparam int IDX_W  = 6;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    logic [24:0] stim  [SLICES];
    logic [24:0] exp_s [SLICES];

    chi_stream_if #(.IDX_W(IDX_W)) bus ();

    chi_stream #(
        .SLICES (SLICES),
        .IDX_W  (IDX_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic logic [24:0] chi_model(input logic [24:0] a);
        logic [24:0] b;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                b[5*y+x] = a[5*y+x] ^ (~a[5*y+(x+1)%5] & a[5*y+(x+2)%5]);
        return b;
    endfunction

    // Runs one state through the DUT; called and returned at a negedge.
    task automatic run_state(input int in_pct, input int out_pct, input int abort_at,
                             input int hold_at, input bit poke_start, input int exp_cycles);
        int          n_in, n_out, n_done, cycles, hold_left;
        bit          held, have_prev;
        logic [24:0] prev_slice;
        logic [5:0]  prev_index;
        n_in = 0; n_out = 0; n_done = 0; cycles = 0; hold_left = 0;
        held = 0; have_prev = 0; prev_slice = '0; prev_index = '0;

        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("busy_after_start", 32'(bus.busy), 1);

        while (n_out < SLICES && cycles < 5000) begin
            if (abort_at > 0 && n_in >= abort_at) break;
            bus.start = poke_start && (cycles == 10);
            if (hold_at >= 0 && n_out == hold_at && !held && bus.out_valid) begin
                hold_left = 5;
                held      = 1;
            end
            bus.out_ready = (hold_left > 0) ? 1'b0 : ($urandom_range(99) < out_pct);
            bus.in_valid  = ($urandom_range(99) < in_pct);
            bus.in_slice  = (n_in < SLICES) ? stim[n_in] : 25'h0AAAAAA;
            #1;
            if (hold_left > 0) begin
                check("hold_in_ready", 32'(bus.in_ready), 0);
                hold_left--;
            end
            if (have_prev) begin
                check("hold_valid", 32'(bus.out_valid), 1);
                check("hold_slice", 32'(bus.out_slice), 32'(prev_slice));
                check("hold_index", 32'(bus.out_index), 32'(prev_index));
            end
            have_prev  = bus.out_valid && !bus.out_ready;
            prev_slice = bus.out_slice;
            prev_index = bus.out_index;
            if (bus.done) n_done++;
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("index_%0d", n_out), 32'(bus.out_index), n_out);
                check($sformatf("slice_%0d", n_out), 32'(bus.out_slice), 32'(exp_s[n_out]));
                n_out++;
            end
            if (bus.in_valid && bus.in_ready) n_in++;
            cycles++;
            @(negedge clk);
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;

        if (abort_at > 0 && n_in >= abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            check("abort_out_valid", 32'(bus.out_valid), 0);
            check("abort_busy", 32'(bus.busy), 0);
            check("abort_done", 32'(bus.done), 0);
            check("abort_in_ready", 32'(bus.in_ready), 0);
            check("abort_done_seen", n_done, 0);
            @(negedge clk);
            #1;
            check("abort_done_later", 32'(bus.done), 0);
            return;
        end

        check("inputs_taken", n_in, SLICES);
        check("outputs_seen", n_out, SLICES);
        check("done_early", n_done, 0);
        if (exp_cycles > 0) check("throughput_cycles", cycles, exp_cycles);

        bus.out_ready = 1'b1;
        bus.start     = poke_start;
        #1;
        check("done_pulse", 32'(bus.done), 1);
        check("done_busy", 32'(bus.busy), 0);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("done_cleared", 32'(bus.done), 0);
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_out_valid", 32'(bus.out_valid), 0);
        check("idle_in_ready", 32'(bus.in_ready), 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_slice  = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_slice", 32'(bus.out_slice), 0);
        check("rst_out_index", 32'(bus.out_index), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);

        // in_valid while IDLE must not be accepted.
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_slice = 25'h0000001;
        #1;
        check("idle_ignore_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        #1;
        check("idle_ignore_valid", 32'(bus.out_valid), 0);
        bus.in_valid = 1'b0;
        @(negedge clk);

        // All-zero state at full throughput: 64 in + 1 cycle latency.
        for (int i = 0; i < SLICES; i++) begin stim[i] = '0; exp_s[i] = '0; end
        run_state(100, 100, 0, -1, 0, SLICES + 1);

        // Hand-computed vectors plus a 5-cycle output stall.
        stim[0] = 25'h0000001; exp_s[0] = 25'h0000009;
        stim[1] = 25'h1FFFFFF; exp_s[1] = 25'h1FFFFFF;
        stim[2] = 25'h0000002; exp_s[2] = 25'h0000012;
        stim[3] = 25'h0000010; exp_s[3] = 25'h0000014;
        run_state(100, 100, 0, 10, 0, 0);

        // Random data with random handshakes; start poked in RUN and DONE.
        for (int i = 0; i < SLICES; i++) begin
            stim[i]  = 25'($urandom);
            exp_s[i] = chi_model(stim[i]);
        end
        run_state(60, 60, 0, -1, 1, 0);

        // Reset after 30 slices, then a fresh full state.
        run_state(100, 100, 30, -1, 0, 0);
        for (int i = 0; i < SLICES; i++) begin
            stim[i]  = 25'($urandom);
            exp_s[i] = chi_model(stim[i]);
        end
        run_state(80, 70, 0, -1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chi_stream.md
Name: chi_stream

Overview:
- Keccak-f chi step, placed directly downstream of the permute (pi) stage.
- Consumes the 5x5x64 state as a stream of 64 slices of 25 bits each, ordered by slice index 0..63.
- Applies chi row-wise to each slice and emits the result with its slice index to the iota stage or file writer.
- Controller FSM, slice counters and a one-entry output pipeline register; valid/ready on both sides.

Parameters:
- SLICES, 64, number of slices per state (lane width); must be a power of two.
- IDX_W, 6, slice index width, equal to log2(SLICES).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle pulse; begins processing of one state.
- in_valid  input  1  in_slice holds a valid slice.
- in_slice  input  25  slice; bit 5*y+x = A[x][y] at this z.
- in_ready  output  1  block accepts in_slice this cycle.
- out_valid  output  1  out_slice/out_index valid.
- out_slice  output  25  chi result, same bit mapping.
- out_index  output  IDX_W  z index of out_slice.
- out_ready  input  1  downstream accepts output this cycle.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  one-cycle pulse after the last slice is accepted downstream.

Behaviour:
- Reset: state IDLE; in_ready=0, out_valid=0, out_slice=0, out_index=0, busy=0, done=0; both counters 0. rst has priority over every other input, including mid-state (no partial output, no done pulse).
- Chi, per row y, for x=0..4: B[x] = A[x] ^ (~A[(x+1) mod 5] & A[(x+2) mod 5]). Purely bitwise, no carries.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_slice/out_index hold stable while out_valid && !out_ready.
- in_ready = (state==RUN) && (!out_valid || out_ready). Combinational on out_ready; no path from in_valid to in_ready.
- Latency: a slice accepted at edge N is visible on out_valid/out_slice after edge N. Full throughput is one slice per cycle when out_ready stays high.
- Counters:
  - in_cnt (IDX_W+1 bits) increments on each input transfer.
  - out_index register loads the in_cnt low bits on each input transfer.
  - out_cnt increments on each output transfer.
- FSM states:
  - IDLE: start -> RUN and clear both counters; otherwise stay.
  - RUN: when the input transfer with in_cnt==SLICES-1 occurs -> DRAIN.
  - DRAIN: in_ready=0. When the output transfer with out_cnt==SLICES-1 occurs -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Boundaries:
  - start outside IDLE is ignored.
  - in_valid outside RUN is ignored; no transfer occurs.
  - Simultaneous output transfer and new input transfer in the same cycle: the register reloads and out_valid stays 1.
  - When the final output transfer occurs in RUN (not possible by construction) the block still enters DRAIN first.
  - An output transfer with no new input clears out_valid.
  - Counter wrap at 64 is never reached; the FSM exits first.

Decomposition:
- Shared package holds:
  - FSM state encodings (IDLE, RUN, DRAIN, DONE).
  - SLICE_W = 25 constant.
  - Lane-index helper constants (5*y+x mapping).
  - These are shared with the permute and iota stages.
- One natural sub-module: chi_slice. It is combinational, 25 bits in and 25 bits out, made of 5 row instances of the chi equation, and is reusable by a future fully-parallel round.

Test Plan:
- Reset, then start, then 64 slices of 0x0000000 with out_ready=1 -> 64 outputs of 0x0000000, indices 0..63 in order, done pulses once, in the cycle after DRAIN ends.
- in_slice=0x0000001 at z=0 -> out_slice=0x0000009. in_slice=0x1FFFFFF -> 0x1FFFFFF. in_slice=0x0000002 -> 0x0000012.
- out_ready held low 5 cycles while out_valid -> in_ready=0, and out_slice/out_index remain constant; on release, one transfer per cycle resumes with no lost or duplicated slice.
- Random in_valid/out_ready toggling over a full state, compared against a software chi model -> all 64 slices match, done asserted exactly once, busy low afterward.
- rst asserted after 30 slices -> next cycle: out_valid=0, busy=0, state IDLE, no done; a fresh start processes 64 slices correctly from index 0.
- start pulsed during RUN and again during DONE -> ignored; slice count and output indices unaffected.
